// File: rtl/bike_light_multi_fsm.sv
// Multi-light bicycle lamp controller: OFF/ON/BLINK/CHASE modes with a saturating speed setting
// that sets the blink/chase half-period in prescaler ticks.
module bike_light_multi_fsm #(
  parameter int unsigned NUM_LIGHTS   = 2,
  parameter int unsigned SPEED_LEVELS = 4,
  parameter int unsigned SPEED_INIT   = 1,
  parameter int unsigned TICK_DIV     = 12500000,
  localparam int unsigned SPD_W       = (SPEED_LEVELS > 2) ? $clog2(SPEED_LEVELS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  faster,
  input  logic                  slower,
  input  logic                  next,
  output logic [NUM_LIGHTS-1:0] lights,
  output logic [1:0]            mode,
  output logic [SPD_W-1:0]      speed
);

  localparam int unsigned PS_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned PTR_W = (NUM_LIGHTS > 1) ? $clog2(NUM_LIGHTS) : 1;

  typedef enum logic [1:0] {StOff = 2'd0, StOn = 2'd1, StBlink = 2'd2, StChase = 2'd3} mode_e;

  mode_e            r_mode, w_mode_nxt;
  logic [SPD_W-1:0] r_speed, w_speed_nxt;
  logic [PS_W-1:0]  r_ps, w_ps_nxt;
  logic [SPD_W-1:0] r_hp, w_hp_nxt;
  logic [PTR_W-1:0] r_ptr, w_ptr_nxt;
  logic             r_phase, w_phase_nxt;
  logic             r_prev_f, r_prev_s, r_prev_n;

  logic             w_press_f, w_press_s, w_press_n;
  logic             w_tick, w_boundary, w_entry;
  logic [31:0]      w_hp_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mode   <= StOff;
      r_speed  <= SPD_W'(SPEED_INIT);
      r_ps     <= '0;
      r_hp     <= '0;
      r_ptr    <= '0;
      r_phase  <= 1'b1;
      // Held buttons must be released before they can register a press.
      r_prev_f <= 1'b1;
      r_prev_s <= 1'b1;
      r_prev_n <= 1'b1;
    end else begin
      r_mode   <= w_mode_nxt;
      r_speed  <= w_speed_nxt;
      r_ps     <= w_ps_nxt;
      r_hp     <= w_hp_nxt;
      r_ptr    <= w_ptr_nxt;
      r_phase  <= w_phase_nxt;
      r_prev_f <= faster;
      r_prev_s <= slower;
      r_prev_n <= next;
    end
  end

  always_comb begin
    w_press_f = faster & ~r_prev_f;
    w_press_s = slower & ~r_prev_s;
    w_press_n = next & ~r_prev_n;

    w_mode_nxt = r_mode;
    if (w_press_n) begin
      unique case (r_mode)
        StOff:   w_mode_nxt = StOn;
        StOn:    w_mode_nxt = StBlink;
        StBlink: w_mode_nxt = (NUM_LIGHTS == 1) ? StOff : StChase;
        StChase: w_mode_nxt = StOff;
        default: w_mode_nxt = StOff;
      endcase
    end

    w_speed_nxt = r_speed;
    if (w_press_f && !w_press_s && r_speed != SPD_W'(SPEED_LEVELS - 1)) begin
      w_speed_nxt = r_speed + 1'b1;
    end else if (w_press_s && !w_press_f && r_speed != '0) begin
      w_speed_nxt = r_speed - 1'b1;
    end

    w_tick   = (r_ps == PS_W'(TICK_DIV - 1));
    w_ps_nxt = w_tick ? '0 : r_ps + 1'b1;

    // >= rather than == so a mid-period speed-up ends the period instead of wrapping.
    w_hp_last  = 32'(SPEED_LEVELS) - 32'(r_speed) - 32'd1;
    w_boundary = w_tick && (32'(r_hp) >= w_hp_last);

    w_hp_nxt    = r_hp;
    w_phase_nxt = r_phase;
    w_ptr_nxt   = r_ptr;
    if (w_tick) begin
      w_hp_nxt = w_boundary ? '0 : r_hp + 1'b1;
    end
    if (w_boundary) begin
      w_phase_nxt = ~r_phase;
      w_ptr_nxt   = (r_ptr == PTR_W'(NUM_LIGHTS - 1)) ? '0 : r_ptr + 1'b1;
    end

    w_entry = (w_mode_nxt != r_mode) && (w_mode_nxt == StBlink || w_mode_nxt == StChase);
    if (w_entry) begin
      w_ps_nxt    = '0;
      w_hp_nxt    = '0;
      w_ptr_nxt   = '0;
      w_phase_nxt = 1'b1;
    end
  end

  always_comb begin
    lights = '0;
    unique case (r_mode)
      StOff:   lights = '0;
      StOn:    lights = '1;
      StBlink: lights = {NUM_LIGHTS{r_phase}};
      StChase: begin
        for (int i = 0; i < NUM_LIGHTS; i++) begin
          lights[i] = (r_ptr == PTR_W'(i));
        end
      end
      default: lights = '0;
    endcase
  end

  assign mode  = r_mode;
  assign speed = r_speed;

endmodule

// File: tb/tb_bike_light_multi_fsm.sv
// Self-checking bench for bike_light_multi_fsm: a vector table for button/mode/speed behaviour
// plus hand-written sequences for blink/chase timing and mid-operation reset.
module tb_bike_light_multi_fsm;

  logic       clk = 1'b0;
  logic       reset, faster, slower, next;
  logic [2:0] lights;
  logic [1:0] mode;
  logic [1:0] speed;

  int n_checks = 0;
  int n_fail   = 0;

  bike_light_multi_fsm #(
    .NUM_LIGHTS  (3),
    .SPEED_LEVELS(4),
    .SPEED_INIT  (1),
    .TICK_DIV    (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .faster(faster),
    .slower(slower),
    .next  (next),
    .lights(lights),
    .mode  (mode),
    .speed (speed)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, f, s, n;
    logic [1:0] m;
    logic [1:0] spd;
    logic [2:0] lt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic f, input logic s, input logic n,
                              input logic [1:0] m, input logic [1:0] spd, input logic [2:0] lt);
    vec_t v;
    v.rst = rst; v.f = f; v.s = s; v.n = n; v.m = m; v.spd = spd; v.lt = lt;
    return v;
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Drive inputs, then sample 1 time unit after the following rising edge.
  task automatic step(input logic r, input logic f, input logic s, input logic n);
    reset = r; faster = f; slower = s; next = n;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_change(output int n);
    logic [2:0] prev;
    prev = lights;
    n = 0;
    while (lights == prev && n < 64) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      n++;
    end
  endtask

  initial begin
    int n;
    int expl;
    // rst f s n | mode speed lights
    vecs.push_back(mk(1, 1, 1, 1, 2'd0, 2'd1, 3'b000));
    vecs.push_back(mk(1, 1, 1, 1, 2'd0, 2'd1, 3'b000));
    vecs.push_back(mk(0, 1, 1, 1, 2'd0, 2'd1, 3'b000));
    vecs.push_back(mk(0, 1, 1, 1, 2'd0, 2'd1, 3'b000));
    vecs.push_back(mk(0, 0, 0, 0, 2'd0, 2'd1, 3'b000));
    vecs.push_back(mk(0, 0, 0, 1, 2'd1, 2'd1, 3'b111));
    vecs.push_back(mk(0, 0, 0, 0, 2'd1, 2'd1, 3'b111));
    vecs.push_back(mk(0, 1, 0, 0, 2'd1, 2'd2, 3'b111));
    vecs.push_back(mk(0, 0, 0, 0, 2'd1, 2'd2, 3'b111));
    vecs.push_back(mk(0, 0, 1, 0, 2'd1, 2'd1, 3'b111));
    vecs.push_back(mk(0, 0, 0, 0, 2'd1, 2'd1, 3'b111));
    vecs.push_back(mk(0, 0, 1, 0, 2'd1, 2'd0, 3'b111));
    vecs.push_back(mk(0, 0, 0, 0, 2'd1, 2'd0, 3'b111));
    vecs.push_back(mk(0, 0, 1, 0, 2'd1, 2'd0, 3'b111));
    vecs.push_back(mk(0, 0, 0, 0, 2'd1, 2'd0, 3'b111));
    vecs.push_back(mk(0, 1, 1, 0, 2'd1, 2'd0, 3'b111));
    vecs.push_back(mk(0, 0, 0, 0, 2'd1, 2'd0, 3'b111));
    vecs.push_back(mk(0, 1, 0, 0, 2'd1, 2'd1, 3'b111));
    vecs.push_back(mk(0, 0, 0, 0, 2'd1, 2'd1, 3'b111));
    vecs.push_back(mk(0, 0, 0, 1, 2'd2, 2'd1, 3'b111));
    vecs.push_back(mk(0, 0, 0, 0, 2'd2, 2'd1, 3'b111));
    vecs.push_back(mk(0, 0, 1, 1, 2'd3, 2'd0, 3'b001));
    vecs.push_back(mk(0, 0, 0, 0, 2'd3, 2'd0, 3'b001));
    vecs.push_back(mk(0, 0, 0, 1, 2'd0, 2'd0, 3'b000));
    vecs.push_back(mk(0, 0, 0, 0, 2'd0, 2'd0, 3'b000));

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].f, vecs[i].s, vecs[i].n);
      check($sformatf("vec%0d mode", i), int'(mode), int'(vecs[i].m));
      check($sformatf("vec%0d speed", i), int'(speed), int'(vecs[i].spd));
      check($sformatf("vec%0d lights", i), int'(lights), int'(vecs[i].lt));
    end

    // Mode cycling with single-cycle next pulses spaced 5 cycles apart (speed 0, HP=4).
    for (int p = 0; p < 4; p++) begin
      int exm;
      int exl;
      exm = (p + 1) % 4;
      exl = (exm == 0) ? 0 : (exm == 3) ? 1 : 7;
      step(1'b0, 1'b0, 1'b0, 1'b1);
      check($sformatf("cycle%0d mode", p), int'(mode), exm);
      check($sformatf("cycle%0d lights", p), int'(lights), exl);
      for (int j = 0; j < 4; j++) begin
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check($sformatf("cycle%0d hold%0d lights", p, j), int'(lights), exl);
      end
    end

    // next held for 20 cycles advances exactly once.
    for (int j = 0; j < 20; j++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1);
      check($sformatf("next_held%0d mode", j), int'(mode), 1);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("speed_to_1", int'(speed), 1);

    // BLINK at speed 1: 12 cycles lit, 12 dark, then lit again.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("blink_entry mode", int'(mode), 2);
    check("blink k0 lights", int'(lights), 7);
    for (int k = 1; k < 36; k++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      expl = (((k / 12) % 2) == 0) ? 7 : 0;
      check($sformatf("blink k%0d lights", k), int'(lights), expl);
    end

    // Four faster presses: 2, 3, then saturates at 3.
    for (int p = 0; p < 4; p++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0);
      check($sformatf("faster%0d speed", p), int'(speed), (p == 0) ? 2 : 3);
      step(1'b0, 1'b0, 1'b0, 1'b0);
    end
    wait_change(n);
    check("blink_align timeout", int'(n < 64), 1);
    wait_change(n);
    check("blink_hp4 period a", n, 4);
    wait_change(n);
    check("blink_hp4 period b", n, 4);

    // CHASE at speed 3: 001, 010, 100, 001 ... every 4 cycles.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("chase_entry mode", int'(mode), 3);
    check("chase k0 lights", int'(lights), 1);
    for (int k = 1; k < 22; k++) begin
      if (k == 2) step(1'b0, 1'b1, 1'b1, 1'b0);
      else step(1'b0, 1'b0, 1'b0, 1'b0);
      expl = 1 << ((k / 4) % 3);
      check($sformatf("chase k%0d lights", k), int'(lights), expl);
      if (k == 2) check("chase both_press speed", int'(speed), 3);
    end

    // Reset mid-CHASE with ptr=2.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("midreset mode", int'(mode), 0);
    check("midreset lights", int'(lights), 0);
    check("midreset speed", int'(speed), 1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    for (int p = 0; p < 3; p++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1);
      check($sformatf("reenter%0d mode", p), int'(mode), p + 1);
      step(1'b0, 1'b0, 1'b0, 1'b0);
    end
    check("reenter chase lights", int'(lights), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bike_light_multi_fsm.md
# bike_light_multi_fsm

Parametrised multi-light bicycle lamp controller, the next generation of the single-output bicycle light FSM. It takes one-pulse or debounced `faster`/`slower`/`next` button levels and cycles OFF -> ON -> BLINK -> CHASE. It drives `NUM_LIGHTS` lamp outputs with a blink/chase rate chosen from `SPEED_LEVELS` saturating speed settings, timed by an internal prescaler. It sits between the button conditioning logic and the lamp drivers.

## Interface
- `NUM_LIGHTS`, 2: number of lamp outputs, ≥1.
- `SPEED_LEVELS`, 4: number of speed settings, ≥2.
- `SPEED_INIT`, 1: speed index loaded at reset, must be < `SPEED_LEVELS`.
- `TICK_DIV`, 12500000: clk cycles per base tick, ≥1.
- `SPD_W`: derived, equal to max(1, clog2(`SPEED_LEVELS`)).
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: synchronous, active-high.
- `faster` input 1: button level; a rising edge raises speed by 1.
- `slower` input 1: button level; a rising edge lowers speed by 1.
- `next` input 1: button level; a rising edge advances the mode.
- `lights` output `NUM_LIGHTS`: lamp drive, 1 means lit.
- `mode` output 2: current mode. 0=OFF, 1=ON, 2=BLINK, 3=CHASE.
- `speed` output `SPD_W`: current speed index.

## Operation
- **Edge detect.**
  - Each button is compared combinationally with its previous-sample register.
  - A press is input=1 while prev=0.
  - Prev registers reset to 1, so a button held through reset does not count as a press until it is released and pressed again.
- **Mode FSM.**
  - A `next` press advances OFF->ON->BLINK->CHASE->OFF.
  - If `NUM_LIGHTS`==1, CHASE is skipped: BLINK->OFF.
- **Speed.**
  - A `faster` press gives speed+1, saturating at `SPEED_LEVELS`-1.
  - A `slower` press gives speed-1, saturating at 0.
  - Speed presses are accepted in every mode.
- **Simultaneous presses.**
  - `faster` and `slower` in the same cycle: speed unchanged.
  - `next` together with `faster`/`slower`: both are applied in that cycle, mode and speed independently.
- **Prescaler.** Counter 0..`TICK_DIV`-1; `tick` is asserted in the cycle the counter equals `TICK_DIV`-1, then the counter wraps to 0.
- **Half-period.**
  - Length `HP` = `SPEED_LEVELS` - speed ticks.
  - On each tick: if hp_cnt ≥ `HP`-1, then boundary, hp_cnt=0. Otherwise hp_cnt+1.
  - Using ≥ makes a speed increase mid-period end the current period at the next tick, never wrap the counter.
- **Entry into BLINK or CHASE.** Prescaler, hp_cnt and chase pointer are cleared to 0; phase is set to 1.
- **Lights decode** (combinational from registered state):
  - OFF: all 0.
  - ON: all 1.
  - BLINK: all bits equal phase; phase toggles at each boundary.
  - CHASE: one-hot 1<<ptr; at each boundary ptr = (ptr+1) mod `NUM_LIGHTS`, wrapping from `NUM_LIGHTS`-1 to 0.
- Boundaries occurring in OFF/ON have no visible effect.

## Timing
- **Reset values:**
  - `mode`=0.
  - `speed`=`SPEED_INIT`.
  - `lights`=0.
  - Prescaler, hp_cnt, ptr = 0; phase=1.
  - Button prev registers = 1.
- **Reset priority.** Reset overrides all other inputs, including a simultaneous press. Reset asserted mid-BLINK/CHASE returns the block to OFF in the same edge.
- **Press latency.**
  - A button rising to 1 before edge N, with prev=0, updates `mode`/`speed` at edge N.
  - `lights` reflects the new mode immediately after edge N.
  - A level held high produces exactly one press.
- **Blink/chase timing.**
  - The first boundary after entry occurs `HP`×`TICK_DIV` cycles after the entry edge.
  - Subsequent boundaries occur every `HP`×`TICK_DIV` cycles while speed is constant.
- **Speed changes.** A change does not reset the prescaler or hp_cnt. It takes effect on the next tick.

## Test plan
All scenarios use `NUM_LIGHTS`=3, `SPEED_LEVELS`=4, `SPEED_INIT`=1, `TICK_DIV`=4.
- **Reset with buttons held.** Reset with all buttons held high, then release reset -> `mode`=0, `speed`=1, `lights`=000. No press is registered until each button goes 0 then 1.
- **Mode cycling.** Four `next` pulses, one cycle each, spaced 5 cycles apart -> `mode` 1,2,3,0; `lights` 111, 111, 001, 000, each change visible right after the sampling edge. A `next` held high for 20 cycles advances only once.
- **BLINK period.** BLINK at speed 1 (`HP`=3) -> `lights`=111 for 12 cycles, 000 for 12, 111, ... Then 3 `faster` presses -> `speed` saturates at 3 and the half-period becomes 4 cycles. One more `faster` -> `speed` stays 3.
- **CHASE order and wrap.** CHASE at speed 3 -> `lights` 001, 010, 100, 001 every 4 cycles. Assert `slower` and `faster` in the same cycle -> `speed` unchanged.
- **Saturation and combined press.** Apply `slower` ×3 from speed 1 -> 0, then 0 (saturates). `next`+`slower` in the same cycle from BLINK -> `mode`=3, and `speed` decrements if >0.
- **Reset mid-operation.** Reset asserted mid-CHASE with ptr=2 -> `mode`=0, `lights`=000, `speed`=1. Re-entering CHASE starts at 001.
